ins_ctrl: RTL

INS_CTRL -- requirements
Module: ins_ctrl

---
 rtl/ins_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ins_ctrl.sv
// ins_ctrl: instruction sequencer for a small operand-memory datapath.
// Loads n_load external words, then fetches/executes prog_len ROM instructions.
// Ports: clk, rst (sync, active-high), start, n_load, prog_len, din_valid,
//   rom_addr/rom_data (1-cycle sync ROM), mul_done, d_in, INS, wr_en,
//   wr_addr, busy, done; err only when ISEQ_TIMEOUT_EN is defined.
// ISEQ_TIMEOUT_EN: adds an 8-bit WAIT_MUL watchdog and the sticky err output.
module ins_ctrl #(
   parameter int PC_W  = 8,
   parameter int ADR_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADR_W-1:0] n_load,
   input  logic [PC_W-1:0]  prog_len,
   input  logic             din_valid,
   output logic [PC_W-1:0]  rom_addr,
   input  logic [ADR_W+2:0] rom_data,
   input  logic             mul_done,
   output logic             d_in,
   output logic [2:0]       INS,
   output logic             wr_en,
   output logic [ADR_W-1:0] wr_addr,
   output logic             busy,
`ifdef ISEQ_TIMEOUT_EN
   output logic             err,
`endif
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE, LOAD, FETCH, EXEC, WAIT_MUL, FIN
   } state_t;

   state_t           state;
   logic [ADR_W-1:0] nload_q;
   logic [ADR_W-1:0] cnt;
   logic [ADR_W-1:0] dst_q;
   logic [PC_W-1:0]  plen_q;
   logic [PC_W-1:0]  pc;
   logic [2:0]       op;
   logic [ADR_W-1:0] dst;
   logic             last_word;
   logic             last_ins;
`ifdef ISEQ_TIMEOUT_EN
   logic [7:0]       wd;
`endif

   assign op        = rom_data[ADR_W+2:ADR_W];
   assign dst       = rom_data[ADR_W-1:0];
   assign last_word = (cnt == nload_q - ADR_W'(1));
   assign last_ins  = (pc == plen_q - PC_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         nload_q <= '0;
         cnt     <= '0;
         dst_q   <= '0;
         plen_q  <= '0;
         pc      <= '0;
`ifdef ISEQ_TIMEOUT_EN
         wd      <= '0;
         err     <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: if (start) begin
               nload_q <= n_load;
               plen_q  <= prog_len;
               cnt     <= '0;
               pc      <= '0;
`ifdef ISEQ_TIMEOUT_EN
               err     <= 1'b0;
`endif
               if (n_load != '0)        state <= LOAD;
               else if (prog_len != '0) state <= FETCH;
               else                     state <= FIN;
            end
            LOAD: if (din_valid) begin
               cnt <= cnt + ADR_W'(1);
               if (last_word)
                  state <= (plen_q != '0) ? FETCH : FIN;
            end
            FETCH: state <= EXEC;
            EXEC: begin
               if (op == 3'd5) begin
                  dst_q <= dst;
`ifdef ISEQ_TIMEOUT_EN
                  wd    <= '0;
`endif
                  state <= WAIT_MUL;
               end else if (last_ins) begin
                  state <= FIN;
               end else begin
                  pc    <= pc + PC_W'(1);
                  state <= FETCH;
               end
            end
            WAIT_MUL: begin
               if (mul_done) begin
                  if (last_ins) begin
                     state <= FIN;
                  end else begin
                     pc    <= pc + PC_W'(1);
                     state <= FETCH;
                  end
`ifdef ISEQ_TIMEOUT_EN
               end else if (wd == 8'd254) begin
                  // 255th idle cycle: abandon the program silently
                  err   <= 1'b1;
                  pc    <= '0;
                  state <= IDLE;
               end else begin
                  wd <= wd + 8'd1;
`endif
               end
            end
            FIN: begin
               pc    <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ROM read and write strobes must line up with the cycle the data
   // arrives, so the datapath controls are decoded from the state register.
   always_comb begin
      d_in    = 1'b0;
      INS     = 3'd0;
      wr_en   = 1'b0;
      wr_addr = '0;
      unique case (state)
         LOAD: begin
            d_in    = 1'b1;
            INS     = 3'd1;
            wr_en   = din_valid;
            wr_addr = cnt;
         end
         EXEC: begin
            wr_addr = dst;
            if (op <= 3'd4) begin
               INS   = op;
               wr_en = 1'b1;
            end else if (op == 3'd5) begin
               INS = 3'd5;
            end
         end
         WAIT_MUL: begin
            INS     = 3'd5;
            wr_addr = dst_q;
            wr_en   = mul_done;
         end
         default: ;
      endcase
   end

   assign rom_addr = pc;
   assign busy     = (state != IDLE);
   assign done     = (state == FIN);

endmodule
